// File: rtl/io_uart_bridge.sv
// Bridges a memory-mapped UART (AXI4-Lite slave) to CPU-side byte streams.
// A poll loop reads STAT and services RX reads / TX writes round-robin through two FIFOs.
module io_uart_bridge #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [7:0]               in_data,
  output logic                     in_vld,
  input  logic                     in_rdy,
  input  logic [7:0]               out_data,
  input  logic                     out_vld,
  output logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [4:0]               err,
  input  logic                     err_clr,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [2:0]               fsm_state
);
  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid, once raised, holds with stable payload.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3
  } state_t;

  state_t state, state_next;
  logic last_write, last_write_next;
  logic tx_ok, rx_ok, illegal;
  logic busy, aw_done, w_done, start, done, read_state;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] addr;
  logic [4:0] err_set;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  // RX FIFO: filled from UART RX register reads, drained by the CPU.
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic          rx_push, rx_pop;

  assign rx_push = (state == READ) && r_hs;
  assign rx_pop  = in_vld && in_rdy;
  assign in_vld  = !rst && (rx_count != '0);
  assign in_data = rx_mem[rx_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rdata[7:0];
  end

  // TX FIFO: filled by the CPU, drained when the UART acknowledges a TX write.
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic          tx_push, tx_pop;

  assign tx_push = out_vld && out_rdy;
  assign tx_pop  = (state == WRITE) && b_hs;
  assign out_rdy = !rst && (tx_count != FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= out_data;
  end

  // Poll FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      last_write <= 1'b0;
    end else begin
      state      <= state_next;
      last_write <= last_write_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_write_next = last_write;
    illegal         = 1'b0;
    tx_ok           = (tx_count != '0) && !rdata[3];
    rx_ok           = (rx_count != FULL) && rdata[0];
    case (state)
      INIT:  if (b_hs) state_next = CHECK;
      CHECK: begin
        if (r_hs) begin
          // On a tie, serve whichever direction did not go last.
          if (tx_ok && (!rx_ok || !last_write)) begin
            state_next      = WRITE;
            last_write_next = 1'b1;
          end else if (rx_ok) begin
            state_next      = READ;
            last_write_next = 1'b0;
          end
        end
      end
      READ:  if (r_hs) state_next = CHECK;
      WRITE: if (b_hs) state_next = CHECK;
      default: begin
        state_next = CHECK;
        illegal    = 1'b1;
      end
    endcase
  end

  assign fsm_state = state;

  // Each state issues exactly one bus transaction; busy spans issue to response.
  assign read_state = (state == CHECK) || (state == READ);
  assign done       = read_state ? r_hs : b_hs;
  assign start      = !busy && !illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (start) begin
        busy <= 1'b1;
        if (read_state) begin
          arvalid <= 1'b1;
        end else begin
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
        end
      end
      if (ar_hs) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (r_hs) rready <= 1'b0;
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (!bready && (aw_done || aw_hs) && (w_done || w_hs)) bready <= 1'b1;
      if (b_hs) begin
        bready  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (done) busy <= 1'b0;
      if (illegal) begin
        busy    <= 1'b0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    case (state)
      INIT:    addr = ADDR_W'(BASE_ADDR + 12);
      READ:    addr = ADDR_W'(BASE_ADDR);
      WRITE:   addr = ADDR_W'(BASE_ADDR + 4);
      default: addr = ADDR_W'(BASE_ADDR + 8);
    endcase
  end

  assign araddr = addr;
  assign awaddr = addr;
  assign wdata  = (state == WRITE) ? {24'b0, tx_mem[tx_rp]} : 32'h0000_0003;
  assign wstrb  = 4'b0001;

  // Sticky error flags: {resp_err, parity, frame, overrun, fsm_illegal}.
  always_comb begin
    err_set    = '0;
    err_set[4] = (r_hs && rresp[1]) || (b_hs && bresp[1]);
    if ((state == CHECK) && r_hs) err_set[3:1] = rdata[7:5];
    err_set[0] = illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= (err_clr ? 5'b0 : err) | err_set;
  end

  logic unused_bits;
  assign unused_bits = ^{rdata[31:8], rresp[0], bresp[0]};
endmodule

// File: tb/tb_io_uart_bridge.sv
// Directed bench for io_uart_bridge: an AXI4-Lite UART slave model plus
// scoreboards for AXI writes, RX stream bytes and data-op ordering.
module tb_io_uart_bridge;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]        in_data, out_data;
  logic              in_vld, in_rdy, out_vld, out_rdy;
  logic [5:0]        rx_count, tx_count;
  logic [4:0]        err;
  logic              err_clr;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic              arvalid, arready, rvalid, rready;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]       rdata, wdata;
  logic [1:0]        rresp;
  logic [1:0]        bresp = 2'b00;
  logic [3:0]        wstrb;
  logic [2:0]        fsm_state;

  io_uart_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .rx_count(rx_count), .tx_count(tx_count),
    .err(err), .err_clr(err_clr),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .fsm_state(fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART slave model
  logic [7:0]  stat_base  = 8'h00;
  logic [1:0]  stat_rresp = 2'b00;
  logic        stat_hold  = 1'b0;
  logic        aw_hold    = 1'b0;
  int          rx_budget  = 0;
  int          rx_served  = 0;
  int          b_count    = 0;
  logic        seen_rd    = 1'b0;
  logic [3:0]  first_rd_addr = 4'h0;
  int          wr_before_rd  = 0;
  logic        aw_got, w_got;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [7:0]  stat_now;

  assign arready  = 1'b1;
  assign wready   = 1'b1;
  assign awready  = !aw_hold;
  assign stat_now = stat_hold ? 8'h08 : (stat_base | {7'b0, (rx_served < rx_budget)});

  always @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        if (araddr == 4'h8) begin
          rdata <= {24'b0, stat_now};
          rresp <= stat_rresp;
        end else if (araddr == 4'h0) begin
          rdata     <= {24'b0, 8'h41 + 8'(rx_served)};
          rresp     <= 2'b00;
          rx_served <= rx_served + 1;
        end else begin
          rdata <= 32'h0;
          rresp <= 2'b00;
        end
        if (!seen_rd) begin
          seen_rd       <= 1'b1;
          first_rd_addr <= araddr;
          wr_before_rd  <= b_count;
        end
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
      if (awvalid && awready) begin
        wr_addr <= awaddr;
        aw_got  <= 1'b1;
      end
      if (wvalid && wready) begin
        wr_data <= wdata;
        wr_strb <= wstrb;
        w_got   <= 1'b1;
      end
      if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)))
        bvalid <= 1'b1;
      if (bvalid && bready) begin
        bvalid  <= 1'b0;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        b_count <= b_count + 1;
      end
    end
  end

  // scoreboards
  logic [39:0] exp_wr[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_op[$];
  logic        op_log_en = 1'b0;

  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {wr_addr, wr_strb, wr_data}, 40'h0);
      else check("wr_txn", {wr_addr, wr_strb, wr_data}, exp_wr.pop_front());
    end
    if (in_vld && in_rdy) begin
      if (exp_rx.size() == 0) check("rx_unexpected", {56'h0, in_data}, 64'h1ff);
      else check("rx_data", in_data, exp_rx.pop_front());
    end
    if (op_log_en && arvalid && arready && araddr == 4'h0) begin
      if (exp_op.size() == 0) check("op_unexpected", 8'h52, 8'h00);
      else check("op_order", 8'h52, exp_op.pop_front());
    end
    if (op_log_en && awvalid && awready && awaddr == 4'h4) begin
      if (exp_op.size() == 0) check("op_unexpected", 8'h57, 8'h00);
      else check("op_order", 8'h57, exp_op.pop_front());
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    out_data = b;
    out_vld  = 1'b1;
    n = 0;
    while (!out_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_timeout", n < 200, 1'b1);
    @(posedge clk); #1;
    out_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_rdy = 1'b0; out_vld = 1'b0; out_data = 8'h00; err_clr = 1'b0;
    cycles(3);
    // reset state
    check("rst_handshakes", {arvalid, rready, awvalid, wvalid, bready, in_vld, out_rdy}, 7'b0);
    check("rst_counts", {rx_count, tx_count}, 12'h0);
    check("rst_err", err, 5'b0);
    check("rst_fsm", fsm_state, 3'd0);

    // first op: CTRL write of 0x3, then STAT read
    exp_wr.push_back({4'hC, 4'b0001, 32'h0000_0003});
    rst = 1'b0;
    n = 0;
    while (!seen_rd && n < 100) begin cycles(1); n++; end
    check("first_read_timeout", n < 100, 1'b1);
    check("first_read_addr", first_rd_addr, 4'h8);
    check("writes_before_first_read", wr_before_rd, 1);
    check("init_write_done", exp_wr.size(), 0);

    // RX saturation then in-order drain
    rx_budget = 40;
    n = 0;
    while (rx_count != 6'd32 && n < 3000) begin cycles(1); n++; end
    check("rx_fill_timeout", n < 3000, 1'b1);
    cycles(60);
    check("rx_saturated", rx_count, 6'd32);
    check("rx_reads_stop", rx_served, 32);
    check("rx_head", {in_vld, in_data}, {1'b1, 8'h41});
    rx_budget = 32;
    cycles(20);
    for (int i = 0; i < 32; i++) exp_rx.push_back(8'h41 + 8'(i));
    in_rdy = 1'b1;
    cycles(32);
    check("rx_drain_rate", rx_count, 6'd0);
    check("rx_drain_all", exp_rx.size(), 0);
    in_rdy = 1'b0;

    // alternating WRITE/READ with both directions pending
    stat_hold = 1'b1;
    cycles(10);
    exp_wr.push_back({4'h4, 4'b0001, 32'h0000_00A1});
    exp_wr.push_back({4'h4, 4'b0001, 32'h0000_00A2});
    exp_wr.push_back({4'h4, 4'b0001, 32'h0000_00A3});
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    check("tx_loaded", tx_count, 6'd3);
    rx_budget = 35;
    exp_rx.push_back(8'h61);
    exp_rx.push_back(8'h62);
    exp_rx.push_back(8'h63);
    for (int i = 0; i < 3; i++) begin
      exp_op.push_back(8'h57);
      exp_op.push_back(8'h52);
    end
    in_rdy    = 1'b1;
    op_log_en = 1'b1;
    stat_hold = 1'b0;
    n = 0;
    while ((tx_count != 0 || rx_served != 35 || exp_rx.size() != 0) && n < 500) begin
      cycles(1); n++;
    end
    check("alt_timeout", n < 500, 1'b1);
    cycles(20);
    check("alt_ops_done", exp_op.size(), 0);
    check("alt_writes_done", exp_wr.size(), 0);
    op_log_en = 1'b0;
    in_rdy    = 1'b0;

    // TX full back-pressure, released by one B handshake
    stat_hold = 1'b1;
    cycles(10);
    for (int i = 0; i < 32; i++) begin
      exp_wr.push_back({4'h4, 4'b0001, 24'h0, 8'hB0 + 8'(i)});
      push_byte(8'hB0 + 8'(i));
    end
    check("tx_full_count", tx_count, 6'd32);
    out_data = 8'hD0;
    out_vld  = 1'b1;
    exp_wr.push_back({4'h4, 4'b0001, 32'h0000_00D0});
    cycles(1);
    check("tx_full_rdy", out_rdy, 1'b0);
    check("tx_full_hold", tx_count, 6'd32);
    stat_hold = 1'b0;
    n = 0;
    while (!(bvalid && bready) && n < 200) begin @(negedge clk); n++; end
    check("tx_b_timeout", n < 200, 1'b1);
    cycles(1);
    check("tx_rdy_after_b", out_rdy, 1'b1);
    check("tx_count_after_b", tx_count, 6'd31);
    cycles(1);
    out_vld = 1'b0;
    check("tx_refill", tx_count, 6'd32);
    n = 0;
    while ((tx_count != 0 || exp_wr.size() != 0) && n < 1500) begin cycles(1); n++; end
    check("tx_drain_timeout", n < 1500, 1'b1);

    // sticky errors and clear
    check("err_clean", err, 5'b0);
    stat_base  = 8'hE0;
    stat_rresp = 2'b10;
    cycles(20);
    check("err_set", err, 5'b11110);
    stat_base  = 8'h00;
    stat_rresp = 2'b00;
    cycles(10);
    check("err_sticky", err, 5'b11110);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_cleared", err, 5'b0);
    cycles(10);
    check("err_stays_clear", err, 5'b0);

    // reset while AW is pending
    aw_hold   = 1'b1;
    rx_budget = 36;
    push_byte(8'hEE);
    n = 0;
    while (!awvalid && n < 200) begin cycles(1); n++; end
    check("aw_wait_timeout", n < 200, 1'b1);
    cycles(3);
    check("aw_pending", awvalid, 1'b1);
    rst = 1'b1;
    cycles(1);
    check("rst_aw_dropped", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_mid_counts", {rx_count, tx_count}, 12'h0);
    check("rst_mid_fsm", fsm_state, 3'd0);
    exp_wr.push_back({4'hC, 4'b0001, 32'h0000_0003});
    aw_hold = 1'b0;
    rst     = 1'b0;
    n = 0;
    while (exp_wr.size() != 0 && n < 100) begin cycles(1); n++; end
    check("reinit_timeout", n < 100, 1'b1);
    cycles(20);

    check("final_wr_queue", exp_wr.size(), 0);
    check("final_rx_queue", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_uart_bridge.md
IO_UART_BRIDGE -- requirements
Module: io_uart_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 32: entries per RX and TX FIFO; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 4: AXI address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0: UART register base; RX=+0x0, TX=+0x4, STAT=+0x8, CTRL=+0xC.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports in_data (output, 8), in_vld (output, 1) and in_rdy (input, 1): RX stream toward the CPU.
REQ-007 SHALL have ports out_data (input, 8), out_vld (input, 1) and out_rdy (output, 1): TX stream from the CPU.
REQ-008 SHALL have ports rx_count and tx_count, output, log2(DEPTH)+1 each: FIFO occupancy.
REQ-009 SHALL have port err, output, 5: sticky {resp_err, parity, frame, overrun, fsm_illegal}.
REQ-010 SHALL have port err_clr, input, 1: clears err.
REQ-011 SHALL have AXI4-Lite master ports araddr/awaddr (ADDR_W), arvalid/arready, rdata (32), rresp (2), rvalid/rready, wdata (32), wstrb (4), wvalid/wready, bresp (2), bvalid/bready.

Function
REQ-012 SHALL use full-capacity FIFOs: DEPTH entries usable, tracked by a count, no sacrificed slot.
REQ-013 SHALL drive in_vld = (rx_count!=0) and in_data = RX head, combinationally from registered state; pop when in_vld&&in_rdy; back-to-back pops one per cycle.
REQ-014 SHALL drive out_rdy = (tx_count!=DEPTH); push out_data when out_vld&&out_rdy; one push per cycle.
REQ-015 SHALL leave a count unchanged on a simultaneous push and pop; a pop at count 1 with no push leaves count 0.
REQ-016 SHALL wrap pointers modulo DEPTH.
REQ-017 SHALL implement FSM states INIT, CHECK, READ, WRITE.
REQ-018 INIT SHALL write 0x00000003 to CTRL once after reset, then go to CHECK.
REQ-019 CHECK SHALL read STAT, then OR rdata[7:5] into err[3:1] and OR rresp[1] into err[4].
REQ-020 After CHECK, tx_ok = (tx_count!=0 && !rdata[3]) and rx_ok = (rx_count!=DEPTH && rdata[0]).
REQ-021 After CHECK, only tx_ok -> WRITE; only rx_ok -> READ; neither -> CHECK.
REQ-022 After CHECK, both tx_ok and rx_ok -> the opposite of the last-served direction, round-robin; last_served resets to READ, so the first tie picks WRITE.
REQ-023 READ SHALL read RX and push rdata[7:0] into the RX FIFO at the R handshake, then go to CHECK.
REQ-024 WRITE SHALL drive wdata={24'b0, TX head} and pop TX at the B handshake, then go to CHECK.
REQ-025 Read transactions SHALL assert arvalid with araddr stable until arready; assert rready the cycle after the AR handshake; hold rready until rvalid.
REQ-026 Write transactions SHALL assert awvalid and wvalid together and drop each independently on its handshake.
REQ-027 Write transactions SHALL assert bready only after both the AW and W handshakes are done, holding it until bvalid.
REQ-028 SHALL hold wstrb = 4'b0001; awaddr and araddr are BASE_ADDR + state offset.
REQ-029 An R or B handshake SHALL OR resp[1] into err[4].
REQ-030 An unreachable FSM encoding SHALL set err[0] and return to CHECK.
REQ-031 err_clr SHALL zero err next cycle; a set event in the same cycle wins for its bit.
REQ-032 CPU-side push and pop SHALL proceed concurrently with any AXI state.

Reset
REQ-033 During rst: all valid/ready outputs 0; FIFOs empty (counts 0, pointers 0); err=0; FSM=INIT; last_served=READ.
REQ-034 Reset mid-transaction SHALL abandon the transaction without completing it; FIFO contents are discarded.

Verification
REQ-035 Release rst, slave accepts -> first AXI op is a write of 0x3 to CTRL, then a STAT read at 0x8.
REQ-036 STAT=0x01 repeatedly, RX data 0x41..0x60, CPU in_rdy=0 -> rx_count saturates at 32 with no further RX reads; in_rdy=1 then drains 0x41..0x60 in order, one per cycle.
REQ-037 CPU pushes 3 bytes while STAT=0x01 and RX data pending -> WRITE and READ alternate; TX bytes appear at 0x4 in push order.
REQ-038 out_vld held with tx_count=32 -> out_rdy=0; one B completes -> out_rdy=1 the next cycle.
REQ-039 STAT=0xE0 with rresp=2'b10 -> err=5'b11110; err_clr pulse -> err=0.
REQ-040 Assert rst while awvalid is pending -> next cycle awvalid=0, counts 0, FSM=INIT.
